// File: rtl/seg_display_arbiter.sv
// Arbitrates the 4-digit seven-segment display between three clients (fixed priority, minimum hold, rotation).
// Optional leading-zero blanking of the owner's digits when SEG_DISPLAY_ARB_LZB_EN is defined.
module seg_display_arbiter #(
  parameter int          HOLD_CYCLES = 25_000_000,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [3:0]  reg1,
  output logic [3:0]  reg2,
  output logic [3:0]  reg3,
  output logic [3:0]  reg4
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [15:0]   BLANK_ALL = {BLANK_CODE, BLANK_CODE, BLANK_CODE, BLANK_CODE};

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [15:0]   digits_q, digits_d;

  logic [2:0]    others;
  logic [15:0]   sel_data;

  function automatic logic [1:0] lowest(input logic [2:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [15:0] shape(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef SEG_DISPLAY_ARB_LZB_EN
    // Blank leading zeros from the left; the rightmost digit always shows.
    if (d[15:12] == 4'h0) begin
      r[15:12] = BLANK_CODE;
      if (d[11:8] == 4'h0) begin
        r[11:8] = BLANK_CODE;
        if (d[7:4] == 4'h0) r[7:4] = BLANK_CODE;
      end
    end
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    others  = req & ~(3'b001 << owner_q);

    if (state_q == S_IDLE) begin
      if (|req) begin
        state_d = S_OWN;
        owner_d = lowest(req);
        cnt_d   = CNT_LOAD;
      end
    end else if (!req[owner_q]) begin
      // Owner released: hand over directly, or fall back to idle.
      if (|others) begin
        owner_d = lowest(others);
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (|others) begin
      owner_d = lowest(others);
      cnt_d   = CNT_LOAD;
    end

    case (owner_d)
      2'd0:    sel_data = data0;
      2'd1:    sel_data = data1;
      default: sel_data = data2;
    endcase

    grant_d  = (state_d == S_OWN) ? (3'b001 << owner_d) : 3'b000;
    busy_d   = (state_d == S_OWN);
    digits_d = (state_d == S_OWN) ? shape(sel_data) : BLANK_ALL;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 2'd0;
      cnt_q    <= '0;
      grant_q  <= 3'b000;
      busy_q   <= 1'b0;
      digits_q <= BLANK_ALL;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      digits_q <= digits_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign reg1  = digits_q[15:12];
  assign reg2  = digits_q[11:8];
  assign reg3  = digits_q[7:4];
  assign reg4  = digits_q[3:0];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed scoreboard bench for seg_display_arbiter with HOLD_CYCLES = 4.
module tb_seg_display_arbiter;

  logic        clk_50m;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  grant;
  logic        busy;
  logic [3:0]  reg1, reg2, reg3, reg4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  g;
    logic        b;
    logic [15:0] d;
    string       tag;
  } exp_t;

  exp_t sb[$];

  seg_display_arbiter #(.HOLD_CYCLES(4), .BLANK_CODE(4'hF)) dut (
    .clk_50m(clk_50m), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .busy(busy),
    .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  // Expected scanner digits for an owner's data word.
  function automatic logic [15:0] disp(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef SEG_DISPLAY_ARB_LZB_EN
    if (d[15:12] == 4'h0) begin
      r[15:12] = 4'hF;
      if (d[11:8] == 4'h0) begin
        r[11:8] = 4'hF;
        if (d[7:4] == 4'h0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] eg,
                      input logic [15:0] ed, input string tag);
    exp_t e;
    logic [15:0] got;
    rst = r;
    req = rq;
    sb.push_back('{g: eg, b: |eg, d: ed, tag: tag});
    @(posedge clk_50m);
    #1;
    e   = sb.pop_front();
    got = {reg1, reg2, reg3, reg4};
    total++;
    assert (grant === e.g) else begin
      bad++;
      $error("FAIL %s grant: observed=%b expected=%b", e.tag, grant, e.g);
    end
    total++;
    assert (busy === e.b) else begin
      bad++;
      $error("FAIL %s busy: observed=%b expected=%b", e.tag, busy, e.b);
    end
    total++;
    assert (got === e.d) else begin
      bad++;
      $error("FAIL %s digits: observed=%h expected=%h", e.tag, got, e.d);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 3'b111;
    data0 = 16'hA5C3;
    data1 = 16'h9876;
    data2 = 16'h1234;

    // Reset held with all clients requesting.
    for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 3'b000, 16'hFFFF, "reset");
    step(1'b0, 3'b111, 3'b001, disp(16'hA5C3), "post_reset_grant");
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, "drop_to_idle");

    // Single request then release.
    step(1'b0, 3'b100, 3'b100, 16'h1234, "single_grant");
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, "single_drop");

    // Client 2 holds 4 cycles while client 0 waits.
    step(1'b0, 3'b100, 3'b100, 16'h1234, "hold_c1");
    for (int i = 0; i < 3; i++) step(1'b0, 3'b101, 3'b100, 16'h1234, "hold_keep");
    step(1'b0, 3'b101, 3'b001, disp(16'hA5C3), "preempt");

    // Rotation between clients 0 and 1.
    for (int i = 0; i < 3; i++) step(1'b0, 3'b011, 3'b001, disp(16'hA5C3), "rot_own0");
    step(1'b0, 3'b011, 3'b010, 16'h9876, "rot_to1");
    data1 = 16'h4321;
    step(1'b0, 3'b011, 3'b010, 16'h4321, "data_update");
    for (int i = 0; i < 2; i++) step(1'b0, 3'b011, 3'b010, 16'h4321, "rot_own1");
    step(1'b0, 3'b011, 3'b001, disp(16'hA5C3), "rot_back0");
    for (int i = 0; i < 3; i++) step(1'b0, 3'b011, 3'b001, disp(16'hA5C3), "rot_own0b");
    step(1'b0, 3'b011, 3'b010, 16'h4321, "rot_to1b");
    step(1'b0, 3'b011, 3'b010, 16'h4321, "own1_mid");

    // Owner 1 drops with 2 hold cycles left; client 2 takes over immediately.
    step(1'b0, 3'b100, 3'b100, 16'h1234, "drop_handover");
    step(1'b1, 3'b100, 3'b000, 16'hFFFF, "mid_hold_reset");
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, "idle_after_reset");
    step(1'b0, 3'b010, 3'b010, 16'h4321, "fresh_after_reset");
    step(1'b0, 3'b000, 3'b000, 16'hFFFF, "idle_again");

    // Leading-zero cases.
    data0 = 16'h0040;
    step(1'b0, 3'b001, 3'b001, disp(16'h0040), "lzb_0040");
    data0 = 16'h0000;
    step(1'b0, 3'b001, 3'b001, disp(16'h0000), "lzb_0000");
    data0 = 16'h0305;
    step(1'b0, 3'b001, 3'b001, disp(16'h0305), "lzb_0305");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
